// File: rtl/fetch_byte_sequencer_if.sv
// Handshake and memory-port bundle for the byte-serial instruction fetch controller.
// master = controller side, slave = fetch stage / memory / decode side.
interface fetch_byte_sequencer_if #(
    parameter int unsigned ADDR_W = 9
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_data_in;
    logic              mem_valid_in;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] instr_addr;
    logic              misaligned_err;

    modport master (
        input  req_valid, req_addr, flush, mem_data_in, mem_valid_in, instr_ready,
        output req_ready, mem_rd_en, mem_rd_addr, instr_valid, instr_out, instr_addr,
               misaligned_err
    );

    modport slave (
        output req_valid, req_addr, flush, mem_data_in, mem_valid_in, instr_ready,
        input  req_ready, mem_rd_en, mem_rd_addr, instr_valid, instr_out, instr_addr,
               misaligned_err
    );
endinterface

// File: rtl/fetch_byte_sequencer.sv
// Fetches a 32-bit instruction as four sequential byte reads from a byte-wide memory and
// hands the assembled word to decode over valid/ready; supports flush and misalign reject.
module fetch_byte_sequencer #(
    parameter int unsigned ADDR_W     = 9,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    fetch_byte_sequencer_if.master bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        issue_q, issue_d;  // reads issued; reused as outstanding count in drain
    logic [2:0]        cap_q, cap_d;
    logic              req_ready_q, req_ready_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic              mis_q, mis_d;
    logic [2:0]        outstanding;
    logic [1:0]        lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            base_q        <= '0;
            issue_q       <= '0;
            cap_q         <= '0;
            req_ready_q   <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_addr_q  <= '0;
            mis_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            issue_q       <= issue_d;
            cap_q         <= cap_d;
            req_ready_q   <= req_ready_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_addr_q  <= instr_addr_d;
            mis_q         <= mis_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        issue_d       = issue_q;
        cap_d         = cap_q;
        req_ready_d   = req_ready_q;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_addr_d  = instr_addr_q;
        mis_d         = 1'b0;
        // A return arriving in the flush cycle is treated as already absorbed.
        outstanding   = issue_q - cap_q - {2'b00, bus.mem_valid_in};
        lane          = BIG_ENDIAN ? (2'd3 - cap_q[1:0]) : cap_q[1:0];

        unique case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q && !bus.flush) begin
                    if (bus.req_addr[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d     = StFetch;
                        base_d      = bus.req_addr;
                        issue_d     = 3'd1;
                        cap_d       = 3'd0;
                        rd_en_d     = 1'b1;
                        rd_addr_d   = bus.req_addr;
                        req_ready_d = 1'b0;
                    end
                end
            end
            StFetch: begin
                if (bus.flush) begin
                    if (outstanding != 3'd0) begin
                        state_d = StDrain;
                        issue_d = outstanding;
                    end else begin
                        state_d     = StIdle;
                        req_ready_d = 1'b1;
                    end
                end else begin
                    if (issue_q != 3'd4) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_q + ADDR_W'(issue_q);
                        issue_d   = issue_q + 3'd1;
                    end
                    if (bus.mem_valid_in) begin
                        instr_out_d[{lane, 3'b000} +: 8] = bus.mem_data_in;
                        cap_d = cap_q + 3'd1;
                        if (cap_q == 3'd3) begin
                            state_d       = StHold;
                            instr_valid_d = 1'b1;
                            instr_addr_d  = base_q;
                        end
                    end
                end
            end
            StHold: begin
                // Flush wins over a same-cycle instr_ready; either way the word leaves.
                if (bus.flush || bus.instr_ready) begin
                    state_d       = StIdle;
                    instr_valid_d = 1'b0;
                    req_ready_d   = 1'b1;
                end
            end
            StDrain: begin
                if (bus.mem_valid_in) begin
                    issue_d = issue_q - 3'd1;
                    if (issue_q == 3'd1) begin
                        state_d     = StIdle;
                        req_ready_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.mem_rd_en      = rd_en_q;
    assign bus.mem_rd_addr    = rd_addr_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr_out      = instr_out_q;
    assign bus.instr_addr     = instr_addr_q;
    assign bus.misaligned_err = mis_q;
endmodule

// File: tb/tb_fetch_byte_sequencer.sv
// Bench for fetch_byte_sequencer: big- and little-endian instances share stimulus and memory,
// checked every cycle against a timeline model plus literal expectations per scenario.
module tb_fetch_byte_sequencer;
    localparam int unsigned AW = 9;
    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inj = 1'b0;
    always #5 clk = ~clk;

    fetch_byte_sequencer_if #(.ADDR_W(AW)) be ();
    fetch_byte_sequencer_if #(.ADDR_W(AW)) le ();

    fetch_byte_sequencer #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .bus(be.master)
    );
    fetch_byte_sequencer #(.ADDR_W(AW), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .bus(le.master)
    );

    assign le.req_valid   = be.req_valid;
    assign le.req_addr    = be.req_addr;
    assign le.flush       = be.flush;
    assign le.instr_ready = be.instr_ready;

    logic [7:0] mem [512];

    // Registered one-cycle memory; inj forces a spurious valid pulse.
    always @(posedge clk) begin
        be.mem_valid_in <= be.mem_rd_en | inj;
        be.mem_data_in  <= be.mem_rd_en ? mem[be.mem_rd_addr] : 8'hA5;
        le.mem_valid_in <= le.mem_rd_en | inj;
        le.mem_data_in  <= le.mem_rd_en ? mem[le.mem_rd_addr] : 8'hA5;
    end

    function automatic logic [31:0] word_be(input logic [8:0] b);
        return {mem[b], mem[b + 9'd1], mem[b + 9'd2], mem[b + 9'd3]};
    endfunction
    function automatic logic [31:0] word_le(input logic [8:0] b);
        return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
    endfunction

    // Timeline model: accept edge E gives reads in cycles E..E+3 and a word from cycle E+5;
    // flush edge tf / handshake edge ths cut those windows short.
    int cyc = 0, e_acc = 0, tf = INF, ths = INF, ready_from = INF, mis_at = -1, last_rd;
    bit have = 1'b0;
    logic [8:0] mbase = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            have = 1'b0;
            ready_from = cyc + 1;
            mis_at = -1;
        end else if (ready_from == INF) begin
            if (be.flush) begin
                tf = cyc;
                last_rd = (cyc - 1 < e_acc + 3) ? cyc - 1 : e_acc + 3;
                ready_from = (cyc > last_rd + 2) ? cyc : last_rd + 2;
            end else if (be.instr_ready && cyc - 1 >= e_acc + 5) begin
                ths = cyc;
                ready_from = cyc;
            end
        end else if (ready_from < cyc && be.req_valid && !be.flush) begin
            if (be.req_addr[1:0] != 2'b00) begin
                mis_at = cyc;
            end else begin
                have = 1'b1;
                e_acc = cyc;
                mbase = be.req_addr;
                tf = INF;
                ths = INF;
                ready_from = INF;
            end
        end
    end

    int checks = 0, errors = 0;
    int vcount = 0, rd_cnt = 0, mis_cnt = 0;
    logic [31:0] last_be = '0, last_le = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        bit e_rd, e_v, e_rdy, e_mis;
        if (rst) begin
            chk("reset_be", 64'({be.req_ready, be.mem_rd_en, be.mem_rd_addr, be.instr_valid,
                be.instr_out, be.instr_addr, be.misaligned_err}), 64'd0);
            chk("reset_le", 64'({le.req_ready, le.mem_rd_en, le.instr_valid, le.instr_out}),
                64'd0);
            return;
        end
        e_rd  = have && cyc >= e_acc && cyc <= e_acc + 3 && cyc < tf;
        e_v   = have && cyc >= e_acc + 5 && cyc < tf && cyc < ths;
        e_rdy = cyc >= ready_from;
        e_mis = cyc == mis_at;
        chk("req_ready", 64'(be.req_ready), 64'(e_rdy));
        chk("mem_rd_en", 64'(be.mem_rd_en), 64'(e_rd));
        if (e_rd) chk("mem_rd_addr", 64'(be.mem_rd_addr), 64'(mbase + 9'(cyc - e_acc)));
        chk("instr_valid", 64'(be.instr_valid), 64'(e_v));
        if (e_v) begin
            chk("instr_out_be", 64'(be.instr_out), 64'(word_be(mbase)));
            chk("instr_addr", 64'(be.instr_addr), 64'(mbase));
            chk("instr_out_le", 64'(le.instr_out), 64'(word_le(mbase)));
        end
        chk("misaligned_err", 64'(be.misaligned_err), 64'(e_mis));
        chk("le_ctrl", 64'({le.req_ready, le.mem_rd_en, le.instr_valid}),
            64'({e_rdy, e_rd, e_v}));
        if (be.instr_valid) vcount++;
        if (be.mem_rd_en) rd_cnt++;
        if (be.misaligned_err) mis_cnt++;
        if (be.instr_valid && be.instr_ready) last_be = be.instr_out;
        if (le.instr_valid && le.instr_ready) last_le = le.instr_out;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_wait(input logic [8:0] a, output int lat);
        be.req_valid = 1'b1;
        be.req_addr  = a;
        tick();
        be.req_valid = 1'b0;
        lat = 1;
        while (!be.instr_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic stimulus();
        int lat, v0, r0, m0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        tick();

        // Aligned fetch, decode always ready
        be.instr_ready = 1'b1;
        v0 = vcount;
        fetch_wait(9'd504, lat);
        chk("t1_latency", 64'(lat), 64'd6);
        repeat (3) tick();
        chk("t1_word_be", 64'(last_be), 64'h001C07E1);
        chk("t1_word_le", 64'(last_le), 64'hE1071C00);
        chk("t1_valid_cycles", 64'(vcount - v0), 64'd1);

        // Backpressure for five cycles
        be.instr_ready = 1'b0;
        v0 = vcount;
        fetch_wait(9'd504, lat);
        repeat (5) tick();
        be.instr_ready = 1'b1;
        tick();
        chk("t2_ready_after_hs", 64'(be.req_ready), 64'd1);
        chk("t2_valid_dropped", 64'(be.instr_valid), 64'd0);
        tick();
        chk("t2_valid_cycles", 64'(vcount - v0), 64'd6);
        chk("t2_word_be", 64'(last_be), 64'h001C07E1);

        // Misaligned request
        m0 = mis_cnt;
        r0 = rd_cnt;
        be.req_valid = 1'b1;
        be.req_addr  = 9'h1E6;
        tick();
        be.req_valid = 1'b0;
        repeat (5) tick();
        chk("t3_mis_pulses", 64'(mis_cnt - m0), 64'd1);
        chk("t3_no_reads", 64'(rd_cnt - r0), 64'd0);
        chk("t3_ready", 64'(be.req_ready), 64'd1);

        // Flush mid-fetch, then a clean fetch of 508
        r0 = rd_cnt;
        v0 = vcount;
        be.req_valid = 1'b1;
        be.req_addr  = 9'd504;
        tick();
        be.req_valid = 1'b0;
        tick();
        tick();
        be.flush = 1'b1;
        tick();
        be.flush = 1'b0;
        chk("t4_rd_low", 64'(be.mem_rd_en), 64'd0);
        repeat (6) tick();
        chk("t4_reads", 64'(rd_cnt - r0), 64'd3);
        chk("t4_no_valid", 64'(vcount - v0), 64'd0);
        chk("t4_ready", 64'(be.req_ready), 64'd1);
        fetch_wait(9'd508, lat);
        repeat (3) tick();
        chk("t4_word_be", 64'(last_be), 64'hF8380078);
        chk("t4_word_le", 64'(last_le), 64'h780038F8);

        // Async reset mid-fetch, late valid, fresh fetch of 0
        be.req_valid = 1'b1;
        be.req_addr  = 9'd504;
        tick();
        be.req_valid = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clear", 64'({be.mem_rd_en, be.req_ready, be.instr_valid}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        tick();
        v0 = vcount;
        fetch_wait(9'd0, lat);
        repeat (3) tick();
        chk("t5_word_be", 64'(last_be), 64'hFFFFFFFF);
        chk("t5_word_le", 64'(last_le), 64'hFFFFFFFF);
        chk("t5_valid_cycles", 64'(vcount - v0), 64'd1);

        // Flush in hold beats a same-cycle instr_ready
        be.instr_ready = 1'b0;
        v0 = vcount;
        fetch_wait(9'd508, lat);
        tick();
        be.flush = 1'b1;
        be.instr_ready = 1'b1;
        tick();
        be.flush = 1'b0;
        be.instr_ready = 1'b0;
        chk("t6_valid_dropped", 64'(be.instr_valid), 64'd0);
        chk("t6_ready", 64'(be.req_ready), 64'd1);
        tick();
        chk("t6_valid_cycles", 64'(vcount - v0), 64'd2);

        // Flush in idle blocks acceptance
        r0 = rd_cnt;
        be.req_valid = 1'b1;
        be.req_addr  = 9'd0;
        be.flush = 1'b1;
        tick();
        be.req_valid = 1'b0;
        be.flush = 1'b0;
        repeat (4) tick();
        chk("t7_blocked", 64'(rd_cnt - r0), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 4; i++) mem[i] = 8'hFF;
        mem[504] = 8'h00; mem[505] = 8'h1C; mem[506] = 8'h07; mem[507] = 8'hE1;
        mem[508] = 8'hF8; mem[509] = 8'h38; mem[510] = 8'h00; mem[511] = 8'h78;
        be.req_valid   = 1'b0;
        be.req_addr    = '0;
        be.flush       = 1'b0;
        be.instr_ready = 1'b0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    compare();
                end
            end
            stimulus();
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
